// File: rtl/gesture_consensus_filter.sv
// Temporal majority-vote filter for classifier results. It keeps a sliding window
// of confident votes and emits one debounced event per majority, then holds off.
module gesture_consensus_filter #(
    parameter int unsigned HISTORY_LEN     = 8,
    parameter int unsigned MIN_VOTES       = 5,
    parameter int unsigned MIN_CONF        = 16,
    parameter int unsigned HOLDOFF_RESULTS = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 6_000_000,
    localparam int unsigned VOTE_BITS      = $clog2(HISTORY_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             in_class,
    input  logic                   in_valid,
    input  logic [7:0]             in_confidence,
    output logic [1:0]             out_class,
    output logic                   out_valid,
    output logic [VOTE_BITS-1:0]   out_votes,
    output logic [7:0]             out_confidence,
    output logic                   out_idle,
    output logic [1:0]             debug_state,
    output logic [4*VOTE_BITS-1:0] debug_counts
);

    localparam int unsigned SIL_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLDOFF_RESULTS + 2);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        EVAL    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Asynchronous assert, clock-synchronised release.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    state_t                              state, state_n;
    logic                                v_q;
    logic [1:0]                          cls_q;
    logic [7:0]                          conf_q;
    logic [HISTORY_LEN-1:0]              win_occ, win_occ_n;
    logic [HISTORY_LEN-1:0][1:0]         win_cls, win_cls_n;
    logic [3:0][VOTE_BITS-1:0]           cnt, cnt_n;
    logic [7:0]                          trig_conf, trig_conf_n;
    logic [HOLD_W-1:0]                   hold_cnt, hold_cnt_n;
    logic [SIL_W-1:0]                    silence, silence_n;
    logic                                idle_n;
    logic [1:0]                          out_class_n;
    logic                                out_valid_n;
    logic [VOTE_BITS-1:0]                out_votes_n;
    logic [7:0]                          out_conf_n;
    logic [1:0]                          best_cls;
    logic [VOTE_BITS-1:0]                best_cnt;
    logic                                timeout_fire, emit, flush, push, new_occ;

    // Next-state, window/counter update and output computation.
    always_comb begin
        state_n      = state;
        win_occ_n    = win_occ;
        win_cls_n    = win_cls;
        cnt_n        = cnt;
        trig_conf_n  = trig_conf;
        hold_cnt_n   = hold_cnt;
        silence_n    = silence;
        idle_n       = out_idle;
        out_class_n  = out_class;
        out_valid_n  = 1'b0;
        out_votes_n  = out_votes;
        out_conf_n   = out_confidence;
        timeout_fire = 1'b0;
        best_cls     = 2'd0;
        best_cnt     = cnt[0];
        new_occ      = conf_q >= 8'(MIN_CONF);

        if (in_valid) begin
            silence_n = '0;
            idle_n    = 1'b0;
        end else if (silence != SIL_W'(TIMEOUT_CYCLES)) begin
            silence_n = silence + SIL_W'(1);
            if (silence_n == SIL_W'(TIMEOUT_CYCLES)) begin
                timeout_fire = 1'b1;
                idle_n       = 1'b1;
            end
        end

        // Strict compare keeps the lowest class on ties.
        for (int c = 1; c < 4; c++) begin
            if (cnt[c] > best_cnt) begin
                best_cnt = cnt[c];
                best_cls = 2'(c);
            end
        end

        emit  = (state == EVAL) && (best_cnt >= VOTE_BITS'(MIN_VOTES));
        flush = emit || timeout_fire;
        push  = v_q && (state != HOLDOFF) && !flush;

        unique case (state)
            ARMED: begin
                if (push) state_n = EVAL;
            end
            EVAL: begin
                if (emit) begin
                    out_class_n = best_cls;
                    out_valid_n = 1'b1;
                    out_votes_n = best_cnt;
                    out_conf_n  = trig_conf;
                    hold_cnt_n  = HOLD_W'(HOLDOFF_RESULTS);
                    state_n     = (HOLDOFF_RESULTS == 0) ? ARMED : HOLDOFF;
                end else begin
                    state_n = push ? EVAL : ARMED;
                end
            end
            HOLDOFF: begin
                if (v_q) begin
                    hold_cnt_n = hold_cnt - HOLD_W'(1);
                    if (hold_cnt <= HOLD_W'(1)) state_n = ARMED;
                end
            end
            default: state_n = ARMED;
        endcase

        if (timeout_fire) begin
            state_n    = ARMED;
            hold_cnt_n = '0;
        end

        if (flush) begin
            win_occ_n = '0;
            cnt_n     = '0;
        end else if (push) begin
            win_occ_n   = {win_occ[HISTORY_LEN-2:0], new_occ};
            win_cls_n   = {win_cls[HISTORY_LEN-2:0], cls_q};
            trig_conf_n = conf_q;
            for (int c = 0; c < 4; c++) begin
                if (new_occ && cls_q == 2'(c))
                    cnt_n[c] = cnt_n[c] + VOTE_BITS'(1);
                if (win_occ[HISTORY_LEN-1] && win_cls[HISTORY_LEN-1] == 2'(c))
                    cnt_n[c] = cnt_n[c] - VOTE_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state          <= ARMED;
            v_q            <= 1'b0;
            cls_q          <= 2'd0;
            conf_q         <= 8'd0;
            win_occ        <= '0;
            win_cls        <= '0;
            cnt            <= '0;
            trig_conf      <= 8'd0;
            hold_cnt       <= '0;
            silence        <= '0;
            out_idle       <= 1'b1;
            out_class      <= 2'd0;
            out_valid      <= 1'b0;
            out_votes      <= '0;
            out_confidence <= 8'd0;
        end else begin
            state          <= state_n;
            v_q            <= in_valid;
            cls_q          <= in_class;
            conf_q         <= in_confidence;
            win_occ        <= win_occ_n;
            win_cls        <= win_cls_n;
            cnt            <= cnt_n;
            trig_conf      <= trig_conf_n;
            hold_cnt       <= hold_cnt_n;
            silence        <= silence_n;
            out_idle       <= idle_n;
            out_class      <= out_class_n;
            out_valid      <= out_valid_n;
            out_votes      <= out_votes_n;
            out_confidence <= out_conf_n;
        end
    end

    assign debug_state  = state;
    assign debug_counts = cnt;

    // Vote counters must stay within 0..HISTORY_LEN.
    always_ff @(posedge clk) begin
        if (rst_int_n) begin
            for (int c = 0; c < 4; c++)
                assert (cnt[c] <= VOTE_BITS'(HISTORY_LEN));
            if (push && win_occ[HISTORY_LEN-1])
                assert (cnt[win_cls[HISTORY_LEN-1]] != '0);
        end
    end

endmodule

// File: tb/tb_gesture_consensus_filter.sv
// Directed bench for gesture_consensus_filter: two instances differing only in
// MIN_VOTES, driven with the same input stream.
module tb_gesture_consensus_filter;

    localparam int unsigned VB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     in_class;
    logic           in_valid;
    logic [7:0]     in_confidence;

    logic [1:0]     out_class,  o4_class;
    logic           out_valid,  o4_valid;
    logic [VB-1:0]  out_votes,  o4_votes;
    logic [7:0]     out_confidence, o4_conf;
    logic           out_idle,   o4_idle;
    logic [1:0]     debug_state, o4_state;
    logic [4*VB-1:0] debug_counts, o4_counts;

    int checks   = 0;
    int failures = 0;
    int p5 = 0;
    int p4 = 0;
    int p0;
    logic [1:0] c5;

    always #5 clk = ~clk;

    gesture_consensus_filter #(
        .HISTORY_LEN(8), .MIN_VOTES(5), .MIN_CONF(16),
        .HOLDOFF_RESULTS(3), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_class(in_class), .in_valid(in_valid),
        .in_confidence(in_confidence), .out_class(out_class), .out_valid(out_valid),
        .out_votes(out_votes), .out_confidence(out_confidence), .out_idle(out_idle),
        .debug_state(debug_state), .debug_counts(debug_counts)
    );

    gesture_consensus_filter #(
        .HISTORY_LEN(8), .MIN_VOTES(4), .MIN_CONF(16),
        .HOLDOFF_RESULTS(3), .TIMEOUT_CYCLES(100)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .in_class(in_class), .in_valid(in_valid),
        .in_confidence(in_confidence), .out_class(o4_class), .out_valid(o4_valid),
        .out_votes(o4_votes), .out_confidence(o4_conf), .out_idle(o4_idle),
        .debug_state(o4_state), .debug_counts(o4_counts)
    );

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            p5 = p5 + 1;
            c5 = out_class;
        end
        if (o4_valid === 1'b1) p4 = p4 + 1;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Called at a negedge; in_valid is sampled by exactly one posedge.
    task automatic send(input logic [1:0] c, input logic [7:0] conf);
        in_class      = c;
        in_confidence = conf;
        in_valid      = 1'b1;
        @(negedge clk);
        in_valid      = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(2'd3, 8'd200);
            repeat (9) @(negedge clk);
        end
        checks++;
        if (debug_state !== 2'd2 || out_class !== 2'd3) begin
            failures++;
            $display("FAIL pre_reset_holdoff: state=%0d class=%0d, required state=2 class=3", debug_state, out_class);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_class !== 2'd0 || out_valid !== 1'b0 || out_votes !== '0 || out_confidence !== 8'd0) begin
            failures++;
            $display("FAIL async_reset_outs: class=%0d valid=%0b votes=%0d conf=%0d, required all 0",
                     out_class, out_valid, out_votes, out_confidence);
        end
        checks++;
        if (out_idle !== 1'b1 || debug_state !== 2'd0 || debug_counts !== '0) begin
            failures++;
            $display("FAIL async_reset_state: idle=%0b state=%0d counts=%h, required idle=1 state=0 counts=0",
                     out_idle, debug_state, debug_counts);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_majority();
        do_reset();
        p0 = p5;
        for (int i = 0; i < 4; i++) begin
            send(2'd2, 8'd100);
            repeat (9) @(negedge clk);
        end
        checks++;
        if (debug_counts !== 16'h0400 || p5 !== p0) begin
            failures++;
            $display("FAIL majority_four: counts=%h pulses=%0d, required counts=0400 pulses=%0d", debug_counts, p5, p0);
        end
        send(2'd2, 8'd100);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL majority_lat0: out_valid=%0b, required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || debug_counts !== 16'h0500) begin
            failures++;
            $display("FAIL majority_lat1: out_valid=%0b counts=%h, required 0 and 0500", out_valid, debug_counts);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_class !== 2'd2 || out_votes !== 4'd5 || out_confidence !== 8'd100) begin
            failures++;
            $display("FAIL majority_emit: valid=%0b class=%0d votes=%0d conf=%0d, required 1/2/5/100",
                     out_valid, out_class, out_votes, out_confidence);
        end
        checks++;
        if (debug_counts !== '0) begin
            failures++;
            $display("FAIL majority_flush: counts=%h, required 0", debug_counts);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL majority_pulse_width: out_valid=%0b, required 0", out_valid);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (p5 !== p0 + 1) begin
            failures++;
            $display("FAIL majority_count: pulses=%0d, required %0d", p5 - p0, 1);
        end
    endtask

    task automatic test_low_conf();
        do_reset();
        p0 = p5;
        for (int i = 0; i < 4; i++) begin
            send(2'd1, 8'd100);
            repeat (9) @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            send(2'd2, 8'd15);
            repeat (9) @(negedge clk);
        end
        checks++;
        if (debug_counts !== 16'h0040) begin
            failures++;
            $display("FAIL lowconf_no_vote: counts=%h, required 0040", debug_counts);
        end
        send(2'd1, 8'd100);
        repeat (9) @(negedge clk);
        checks++;
        if (debug_counts !== 16'h0040 || p5 !== p0) begin
            failures++;
            $display("FAIL lowconf_aging: counts=%h pulses=%0d, required counts=0040 pulses=0", debug_counts, p5 - p0);
        end
    endtask

    task automatic test_holdoff();
        do_reset();
        p0 = p5;
        for (int i = 0; i < 5; i++) begin
            send(2'd0, 8'd100);
            repeat (9) @(negedge clk);
        end
        checks++;
        if (p5 !== p0 + 1 || c5 !== 2'd0 || debug_state !== 2'd2) begin
            failures++;
            $display("FAIL holdoff_entry: pulses=%0d class=%0d state=%0d, required 1/0/2", p5 - p0, c5, debug_state);
        end
        for (int i = 0; i < 3; i++) begin
            send(2'd0, 8'd100);
            repeat (9) @(negedge clk);
            checks++;
            if (debug_counts !== '0) begin
                failures++;
                $display("FAIL holdoff_drop%0d: counts=%h, required 0", i, debug_counts);
            end
        end
        checks++;
        if (debug_state !== 2'd0) begin
            failures++;
            $display("FAIL holdoff_exit: state=%0d, required 0", debug_state);
        end
        for (int i = 0; i < 5; i++) begin
            send(2'd0, 8'd100);
            repeat (9) @(negedge clk);
        end
        checks++;
        if (p5 !== p0 + 2 || debug_counts !== '0) begin
            failures++;
            $display("FAIL holdoff_second: pulses=%0d counts=%h, required 2 and 0", p5 - p0, debug_counts);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        p0 = p5;
        send(2'd3, 8'd100);
        repeat (9) @(negedge clk);
        send(2'd3, 8'd100);
        repeat (9) @(negedge clk);
        send(2'd3, 8'd100);
        @(negedge clk);
        checks++;
        if (debug_counts !== 16'h3000 || out_idle !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pre: counts=%h idle=%0b, required 3000 and 0", debug_counts, out_idle);
        end
        repeat (98) @(negedge clk);
        checks++;
        if (out_idle !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: idle=%0b after 99 cycles, required 0", out_idle);
        end
        @(negedge clk);
        checks++;
        if (out_idle !== 1'b1 || debug_counts !== '0) begin
            failures++;
            $display("FAIL timeout_fire: idle=%0b counts=%h, required 1 and 0", out_idle, debug_counts);
        end
        send(2'd3, 8'd100);
        checks++;
        if (out_idle !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle_clear: idle=%0b, required 0", out_idle);
        end
        repeat (9) @(negedge clk);
        send(2'd3, 8'd100);
        repeat (9) @(negedge clk);
        checks++;
        if (debug_counts !== 16'h2000 || p5 !== p0) begin
            failures++;
            $display("FAIL timeout_after: counts=%h pulses=%0d, required 2000 and 0", debug_counts, p5 - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [6];
        seq = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        do_reset();
        p0 = p4;
        for (int i = 0; i < 6; i++) begin
            send(seq[i], 8'd100);
            repeat (9) @(negedge clk);
        end
        checks++;
        if (o4_counts !== 16'h3030) begin
            failures++;
            $display("FAIL tie_counts: counts=%h, required 3030", o4_counts);
        end
        send(2'd1, 8'd100);
        send(2'd3, 8'd100);
        @(negedge clk);
        checks++;
        if (o4_valid !== 1'b1 || o4_class !== 2'd1 || o4_votes !== 4'd4) begin
            failures++;
            $display("FAIL tie_emit: valid=%0b class=%0d votes=%0d, required 1/1/4", o4_valid, o4_class, o4_votes);
        end
        checks++;
        if (o4_counts !== '0 || o4_state !== 2'd2) begin
            failures++;
            $display("FAIL tie_flush_drop: counts=%h state=%0d, required 0 and 2", o4_counts, o4_state);
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            send(2'd2, 8'd100);
            repeat (9) @(negedge clk);
        end
        checks++;
        if (o4_state !== 2'd2 || p4 !== p0 + 1) begin
            failures++;
            $display("FAIL tie_holdoff_len: state=%0d pulses=%0d, required 2 and 1", o4_state, p4 - p0);
        end
        send(2'd2, 8'd100);
        repeat (9) @(negedge clk);
        checks++;
        if (o4_state !== 2'd0 || o4_counts !== '0) begin
            failures++;
            $display("FAIL tie_holdoff_exit: state=%0d counts=%h, required 0 and 0", o4_state, o4_counts);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_class      = 2'd0;
        in_confidence = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_idle !== 1'b1 || debug_state !== 2'd0 || debug_counts !== '0 ||
            out_class !== 2'd0 || out_votes !== '0 || out_confidence !== 8'd0) begin
            failures++;
            $display("FAIL power_on_reset: valid=%0b idle=%0b state=%0d counts=%h, required 0/1/0/0",
                     out_valid, out_idle, debug_state, debug_counts);
        end
        test_reset();
        test_majority();
        test_low_conf();
        test_holdoff();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gesture_consensus_filter.md
# gesture_consensus_filter

Temporal vote filter directly downstream of the spatio-temporal classifier. It consumes the per-frame `gesture_class` / `gesture_valid` / `gesture_confidence` results and keeps a sliding window of recent confident results. It emits a single debounced gesture event when one class holds a majority of that window, then flushes the window and enters a hold-off. Its output drives the host/UART reporting path and the LEDs in place of the raw per-frame classifier output.

## Interface
- `HISTORY_LEN`, default 8: window depth in results, range 2..16.
- `MIN_VOTES`, default 5: votes one class needs to emit, range 1..HISTORY_LEN.
- `MIN_CONF`, default 16: minimum `in_confidence` for an input to count as a vote.
- `HOLDOFF_RESULTS`, default 3: number of `in_valid` pulses dropped after an emission.
- `TIMEOUT_CYCLES`, default 6_000_000: number of silent cycles before the window flushes (50 frames at 12 MHz / 10 ms).
- `VOTE_BITS`, derived as $clog2(HISTORY_LEN+1): width of each vote counter.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_class` in 2: classifier `gesture_class`.
- `in_valid` in 1: classifier `gesture_valid`, a one-cycle pulse.
- `in_confidence` in 8: classifier `gesture_confidence`.
- `out_class` out 2: class of the emitted event.
- `out_valid` out 1: one-cycle pulse, one per emitted event.
- `out_votes` out VOTE_BITS: winning class's vote count at the moment of emission.
- `out_confidence` out 8: `in_confidence` of the input that triggered the emission.
- `out_idle` out 1: high while the timeout is expired (no input seen recently).
- `debug_state` out 2: current FSM state (ARMED=0, EVAL=1, HOLDOFF=2).
- `debug_counts` out 4*VOTE_BITS: the four vote counters packed flat, class 0 at the LSB.

## Operation
- Window: a HISTORY_LEN-entry shift register, one entry per result. Each entry is {occupied bit, 2-bit class}.
- Four per-class counters are kept incrementally. On each push:
  - Increment the counter for the class entering the window.
  - Decrement the counter for the evicted entry if that entry was occupied.
  - If the same class enters and leaves, the counter is unchanged.
- Input acceptance: `in_valid` is ignored while in HOLDOFF (apart from counting).
  - With `in_confidence >= MIN_CONF`: push an occupied entry with `in_class`.
  - With `in_confidence < MIN_CONF`: push an unoccupied entry. This ages the window without adding a vote.
- FSM states and transitions:
  - ARMED: a push moves the FSM to EVAL.
  - EVAL (exactly 1 cycle, counters already updated):
    - Argmax over the four counters; ties resolve to the lowest class index.
    - If max >= MIN_VOTES: register outputs, pulse `out_valid`, flush the window (all entries unoccupied, counters 0), load the hold-off counter with HOLDOFF_RESULTS, go to HOLDOFF. If HOLDOFF_RESULTS = 0, go straight to ARMED.
    - Otherwise return to ARMED with no output.
  - HOLDOFF: each `in_valid` decrements the hold-off counter and the input is discarded. When the counter reaches 0, go to ARMED.
- Timeout:
  - A silence counter resets to 0 on any `in_valid` (regardless of confidence or state). Otherwise it counts up, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: flush the window, force the FSM to ARMED (this cancels any hold-off), and set `out_idle`.
  - `out_idle` clears on the cycle after the next `in_valid`.
- Arithmetic: all counters are unsigned.
  - A vote counter never exceeds HISTORY_LEN or goes below 0. A violation is an assertion failure.

## Timing
- Reset values (asserted asynchronously):
  - `out_class`=0, `out_valid`=0, `out_votes`=0, `out_confidence`=0, `debug_counts`=0.
  - `out_idle`=1, FSM=ARMED, window empty, silence counter=0, hold-off counter=0.
- Release of `rst_n` is synchronised to `clk` internally.
- Latency: with `in_valid` sampled at edge N, counters update at N+1 and `out_valid` is high for one cycle starting at N+2.
- `in_valid` arriving while in EVAL is pushed normally, and EVAL repeats on the next cycle.
  - If that EVAL emits, the flush has priority over the push: the new input is dropped and does not count toward hold-off.
- Timeout and an emission on the same cycle: the emission is output, then the timeout flush applies and the FSM goes to ARMED.
- No backpressure; inputs arrive at most once per cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-HOLDOFF with no clock edge. All outputs take their reset values immediately, `out_idle`=1, `debug_state`=0.
- Majority: 5× class 2, conf 100, 10 cycles apart. `out_valid` pulses once, 2 cycles after the 5th input, with `out_class`=2, `out_votes`=5, `out_confidence`=100. `debug_counts` is 0 afterwards.
- Low confidence and aging (HISTORY_LEN=8): 4× class 1 conf 100, then 4× conf 15, then 1× class 1 conf 100. Counter 1 ends at 4 (a class-1 entry is evicted), and there is no `out_valid`.
- Hold-off (HOLDOFF_RESULTS=3): after an emission on class 0, send 3× class 0. All are dropped and counters stay 0. Then 5 more class 0 inputs produce a second pulse.
- Timeout (TIMEOUT_CYCLES=100): 3× class 3, then 100 idle cycles. `out_idle` rises and counters are 0. Then 2× class 3 produce no output, and `out_idle` falls.
- Tie and back-to-back (MIN_VOTES=4): send 3,1,3,1,3,1 and then 1 and 3 on consecutive cycles.
  - Emission is class 1 (it reaches 4 first).
  - The following class-3 input lands in the flush cycle and is dropped.
